// File: rtl/convertidor.sv
`default_nettype none
// ============================================================================
// Module      : convertidor
// Description : Serial-to-parallel byte packer for the PHY receive datapath.
//               Gathers bytes from in_data on enabled CLK edges and packs them
//               into an 8/16/32-bit word selected by PCLK. The completed word
//               appears on OUT_DATA (zero-extended). The partial word and the
//               index of the next byte slot are exported for debug.
//               The slot index port is named bit_idx because "bit" is a
//               reserved word in SystemVerilog.
//               Optional macro CONV_VALID_EN adds a registered VALID output
//               that pulses high on every edge that completes a word.
// Revision    : 1.0 - initial release
// ============================================================================
module convertidor #(
    parameter logic [31:0] RESET_WORD = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        ENB,
    input  logic [1:0]  PCLK,
    input  logic [7:0]  in_data,
    output logic [31:0] OUT_DATA,
    output logic [1:0]  bit_idx,
    output logic [31:0] part
`ifdef CONV_VALID_EN
    ,
    output logic        VALID
`endif
);

    localparam logic [1:0] C_LAST_8  = 2'd0;
    localparam logic [1:0] C_LAST_16 = 2'd1;
    localparam logic [1:0] C_LAST_32 = 2'd3;

    logic [1:0]  w_last;        // slot index that finishes a word in this mode
    logic        w_complete;    // this edge consumes the final byte of a word
    logic [31:0] w_merged;      // part with the current slot replaced by in_data
    logic [31:0] w_keep_mask;   // keeps slots 0..bit_idx, clears the rest
    logic [31:0] w_word;        // completed word, upper slots forced to zero

    // Decode the final slot index for the mode sampled on this edge
    always_comb begin
        w_last = C_LAST_32;
        case (PCLK)
            2'b00:   w_last = C_LAST_8;
            2'b01:   w_last = C_LAST_16;
            default: w_last = C_LAST_32;
        endcase
    end

    // A word completes when the slot being filled is at or past the final
    // slot; covers a narrowing mode change in the middle of a word
    assign w_complete = ENB && (bit_idx >= w_last);

    // Insert the incoming byte into its slot and mask off the slots above it
    always_comb begin
        w_merged    = part;
        w_keep_mask = 32'h0000_00FF;
        case (bit_idx)
            2'd0: begin
                w_merged[7:0]   = in_data;
                w_keep_mask     = 32'h0000_00FF;
            end
            2'd1: begin
                w_merged[15:8]  = in_data;
                w_keep_mask     = 32'h0000_FFFF;
            end
            2'd2: begin
                w_merged[23:16] = in_data;
                w_keep_mask     = 32'h00FF_FFFF;
            end
            default: begin
                w_merged[31:24] = in_data;
                w_keep_mask     = 32'hFFFF_FFFF;
            end
        endcase
        w_word = w_merged & w_keep_mask;
    end

    // Packing state: accumulate into part, publish on completion, hold when idle
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            OUT_DATA <= RESET_WORD;
            part     <= RESET_WORD;
            bit_idx  <= 2'd0;
        end else if (ENB) begin
            if (w_complete) begin
                OUT_DATA <= w_word;
                part     <= 32'h0000_0000;
                bit_idx  <= 2'd0;
            end else begin
                part     <= w_merged;
                bit_idx  <= bit_idx + 2'd1;
            end
        end
    end

`ifdef CONV_VALID_EN
    // One-cycle strobe for every completed word; stays high for back-to-back words
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            VALID <= 1'b0;
        end else begin
            VALID <= w_complete;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_convertidor.sv
`default_nettype none
// ============================================================================
// Module      : tb_convertidor
// Description : Self-checking bench for convertidor. Directed scenarios plus
//               randomized traffic compared against a byte-list reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_convertidor;

    logic        CLK;
    logic        RESET;
    logic        ENB;
    logic [1:0]  PCLK;
    logic [7:0]  in_data;
    logic [31:0] OUT_DATA;
    logic [1:0]  bit_idx;
    logic [31:0] part;
`ifdef CONV_VALID_EN
    logic        VALID;
`endif

    int checks   = 0;
    int failures = 0;

    convertidor #(.RESET_WORD(32'h0000_0000)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .ENB      (ENB),
        .PCLK     (PCLK),
        .in_data  (in_data),
        .OUT_DATA (OUT_DATA),
        .bit_idx  (bit_idx),
        .part     (part)
`ifdef CONV_VALID_EN
        ,
        .VALID    (VALID)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference: list of bytes collected so far for the current word
    logic [7:0]  m_bytes [4];
    int          m_n;
    logic [31:0] m_out;
    logic        m_valid;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int bytes_per_word(input logic [1:0] p);
        if (p == 2'b00) return 1;
        if (p == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] model_part();
        logic [31:0] v = 32'h0;
        for (int k = 0; k < m_n; k++) v = v | ({24'h0, m_bytes[k]} << (8 * k));
        return v;
    endfunction

    task automatic model_reset();
        m_n = 0;
        m_out = 32'h0;
        m_valid = 1'b0;
        for (int k = 0; k < 4; k++) m_bytes[k] = 8'h00;
    endtask

    task automatic model_edge(input logic en, input logic [1:0] p, input logic [7:0] d);
        m_valid = 1'b0;
        if (en) begin
            m_bytes[m_n] = d;
            if (m_n + 1 >= bytes_per_word(p)) begin
                m_out = 32'h0;
                for (int k = 0; k <= m_n; k++) m_out = m_out | ({24'h0, m_bytes[k]} << (8 * k));
                m_n = 0;
                m_valid = 1'b1;
            end else begin
                m_n = m_n + 1;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check_eq({tag, ".out"},  OUT_DATA, m_out);
        check_eq({tag, ".part"}, part, model_part());
        check_eq({tag, ".bit"},  {30'h0, bit_idx}, m_n[31:0]);
`ifdef CONV_VALID_EN
        check_eq({tag, ".valid"}, {31'h0, VALID}, {31'h0, m_valid});
`endif
    endtask

    // Drive one cycle of inputs, advance one edge, then sample just after it
    task automatic step(input logic en, input logic [1:0] p, input logic [7:0] d);
        ENB = en;
        PCLK = p;
        in_data = d;
        @(posedge CLK);
        model_edge(en, p, d);
        #1;
    endtask

    // Assert reset between edges and check it takes effect without a clock edge
    task automatic async_reset(input string tag);
        RESET = 1'b1;
        #2;
        model_reset();
        compare_all(tag);
        check_eq({tag, ".zero"}, OUT_DATA | part | {30'h0, bit_idx}, 32'h0);
        RESET = 1'b0;
    endtask

    logic [7:0] seq [4];

    initial begin
        RESET = 1'b1;
        ENB = 1'b0;
        PCLK = 2'b10;
        in_data = 8'h00;
        model_reset();
        #12;
        compare_all("reset");
        @(posedge CLK);
        #1;
        RESET = 1'b0;

        // 32-bit mode
        seq = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 2'b10, seq[i]);
            compare_all("w32");
            check_eq("w32.bitseq", {30'h0, bit_idx}, (i + 1) % 4);
        end
        check_eq("w32.word", OUT_DATA, 32'h4433_2211);
        check_eq("w32.partclr", part, 32'h0);

        // 16-bit mode
        seq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 2'b01, seq[i]);
            compare_all("w16");
            if (i == 1) check_eq("w16.first", OUT_DATA, 32'h0000_BBAA);
        end
        check_eq("w16.second", OUT_DATA, 32'h0000_DDCC);

        // 8-bit mode
        step(1'b1, 2'b00, 8'h5A);
        check_eq("w8.first", OUT_DATA, 32'h0000_005A);
        check_eq("w8.bit", {30'h0, bit_idx}, 32'h0);
        step(1'b1, 2'b00, 8'hA5);
        check_eq("w8.second", OUT_DATA, 32'h0000_00A5);
        compare_all("w8");

        // Enable gap inside a word
        step(1'b1, 2'b10, 8'h01);
        step(1'b1, 2'b10, 8'h02);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 2'b10, 8'hF0 ^ 8'(i * 37));
            compare_all("gap");
            check_eq("gap.part", part, 32'h0000_0201);
        end
        step(1'b1, 2'b10, 8'h03);
        step(1'b1, 2'b10, 8'h04);
        check_eq("gap.word", OUT_DATA, 32'h0403_0201);
        compare_all("gap.end");

        // Mode narrows mid-word
        step(1'b1, 2'b10, 8'h10);
        step(1'b1, 2'b10, 8'h20);
        step(1'b1, 2'b10, 8'h30);
        check_eq("sw.bit3", {30'h0, bit_idx}, 32'd3);
        step(1'b1, 2'b01, 8'h40);
        check_eq("sw.word", OUT_DATA, 32'h4030_2010);
        compare_all("sw");
`ifdef CONV_VALID_EN
        check_eq("sw.valid", {31'h0, VALID}, 32'd1);
        step(1'b0, 2'b01, 8'h00);
        check_eq("sw.validlo", {31'h0, VALID}, 32'd0);
`endif

        // Reset mid-stream with ENB high
        step(1'b1, 2'b10, 8'h77);
        step(1'b1, 2'b10, 8'h88);
        ENB = 1'b1;
        async_reset("midrst");

        // Randomized traffic with occasional mode changes, gaps and resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                async_reset("rnd.rst");
            end else begin
                step(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 8'($urandom));
                compare_all("rnd");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
